// File: rtl/gate_tt_checker.sv
// gate_tt_checker: exhaustive truth-table checker for a 2-input logic gate.
// On start it drives the four input vectors 00, 01, 10, 11 in order. Each
// vector is held for SETTLE_CYCLES cycles and then sampled for one cycle.
// The sampled dut_y is compared against the function chosen by func_sel,
// which is latched when the pass is accepted. Mismatches are recorded per
// vector in fail_vec and counted in err_count.
// Optional feature: define TT_EARLY_ABORT_EN to end the pass on the first
// mismatch instead of always running all four vectors.
module gate_tt_checker #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func_sel,
  input  logic       dut_y,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  // The settle counter counts down to zero, so an entry value of
  // SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles in SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [2:0] func_q;
  logic [1:0] idx_q;        // current vector; doubles as {drv_a, drv_b}
  logic [3:0] settle_cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [2:0] err_count_q;
  logic [3:0] fail_vec_q;

  logic       exp_y;
  logic       mismatch;
  logic [2:0] err_count_d;
  logic [3:0] fail_vec_d;
  logic       last_sample;

  // Expected gate output for the vector currently driven, and the
  // mismatch bookkeeping that a SAMPLE cycle would commit.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    exp_y       = 1'b0;
    mismatch    = 1'b0;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    last_sample = 1'b0;

    case (func_q)
      3'd0:    exp_y = idx_q[1] & idx_q[0];
      3'd1:    exp_y = idx_q[1] | idx_q[0];
      3'd2:    exp_y = ~(idx_q[1] & idx_q[0]);
      3'd3:    exp_y = ~(idx_q[1] | idx_q[0]);
      3'd4:    exp_y = idx_q[1] ^ idx_q[0];
      3'd5:    exp_y = ~(idx_q[1] ^ idx_q[0]);
      default: exp_y = ~(idx_q[1] | idx_q[0]);  // 6 and 7 behave as NOR
    endcase

    mismatch = (dut_y != exp_y);
    if (mismatch) begin
      err_count_d = err_count_q + 3'd1;
      fail_vec_d  = fail_vec_q | (4'b0001 << idx_q);
    end

`ifdef TT_EARLY_ABORT_EN
    last_sample = (idx_q == 2'd3) || mismatch;
`else
    last_sample = (idx_q == 2'd3);
`endif
  end

  // Control FSM with registered outputs; all status flags are updated on
  // the same edge as the state transition that defines them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      func_q       <= 3'd0;
      idx_q        <= 2'd0;
      settle_cnt_q <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= 3'd0;
      fail_vec_q   <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            func_q       <= func_sel;
            err_count_q  <= 3'd0;
            fail_vec_q   <= 4'd0;
            pass_q       <= 1'b0;
            idx_q        <= 2'd0;
            settle_cnt_q <= SETTLE_LOAD;
            busy_q       <= 1'b1;
            state_q      <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt_q == 4'd0) begin
            state_q <= SAMPLE;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end

        SAMPLE: begin
          err_count_q <= err_count_d;
          fail_vec_q  <= fail_vec_d;
          if (last_sample) begin
            // pass must reflect this final sample, hence the _d values.
            pass_q  <= (err_count_d == 3'd0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q        <= idx_q + 2'd1;
            settle_cnt_q <= SETTLE_LOAD;
            state_q      <= SETTLE;
          end
        end

        DONE: begin
          // start is deliberately ignored here, even if it is high.
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign drv_a     = idx_q[1];
  assign drv_b     = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
